// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// One valid/ready channel carrying a control field and a datapath field
// between two CPU pipeline stages.
//
// Signals:
//   valid  beat is present (driven by the producer)
//   ready  consumer can take the beat (driven by the consumer)
//   ctrl   control field, CTRL_W bits (driven by the producer)
//   data   datapath field, DATA_W bits (driven by the producer)
//
// Modports:
//   master  producer side (drives valid/ctrl/data, observes ready)
//   slave   consumer side (observes valid/ctrl/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 175
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline-stage register placed at each CPU stage boundary
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Moves a control field and a datapath field
// with valid/ready flow control, squashes its contents on a synchronous
// flush, and counts back-pressure cycles in a saturating counter.
//
// Optional feature: define PIPE_SKID_EN to add a second (skid) entry. in_ready
// then comes straight from a register, breaking the combinational path from
// downstream ready to upstream ready while keeping one beat per cycle.
// Without the macro the stage is a single entry with combinational in_ready.
//
// Ports:
//   CLK        clock, rising edge
//   CLR_N      asynchronous active-low reset
//   flush      synchronous squash of stage contents and of the incoming beat
//   inBus      slave channel from the upstream stage (in_valid/in_ready/
//              in_ctrl/in_data)
//   outBus     master channel to the downstream stage (out_valid/out_ready/
//              out_ctrl/out_data)
//   stall_cnt  saturating count of cycles with out_valid=1, out_ready=0,
//              flush=0
//
// Parameters:
//   CTRL_W, DATA_W        field widths (must match the interface instances)
//   CLEAR_DATA_ON_FLUSH   1: flushes/bubbles also zero the data field
//   CNT_W                 width of stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W              = 14,
  parameter int DATA_W              = 175,
  parameter int CLEAR_DATA_ON_FLUSH = 0,
  parameter int CNT_W               = 16
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              flush,
  pipe_stage_reg_if.slave   inBus,
  pipe_stage_reg_if.master  outBus,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              mainVld_p1;
  logic [CTRL_W-1:0] mainCtrl_p1;
  logic [DATA_W-1:0] mainData_p1;
  logic [CNT_W-1:0]  stallCnt_p1;

  logic inFire;
  logic outFire;
  logic stallNow;

  assign outFire  = mainVld_p1 & outBus.ready;
  assign inFire   = inBus.valid & inBus.ready;
  // Flush cycles are not stalls: the beat is being thrown away, not held.
  assign stallNow = mainVld_p1 & ~outBus.ready & ~flush;

  assign outBus.valid = mainVld_p1;
  assign outBus.ctrl  = mainCtrl_p1;
  assign outBus.data  = mainData_p1;
  assign stall_cnt    = stallCnt_p1;

`ifdef PIPE_SKID_EN

  logic              skidVld_p1;
  logic [CTRL_W-1:0] skidCtrl_p1;
  logic [DATA_W-1:0] skidData_p1;

  // Ready depends only on local state, so no combinational path from
  // outBus.ready reaches inBus.ready.
  assign inBus.ready = ~skidVld_p1;

  // ---- stage p1: main + skid entries ----
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mainVld_p1  <= 1'b0;
      mainCtrl_p1 <= '0;
      mainData_p1 <= '0;
      skidVld_p1  <= 1'b0;
      skidCtrl_p1 <= '0;
      skidData_p1 <= '0;
      stallCnt_p1 <= '0;
    end else begin
      if (flush) begin
        mainVld_p1  <= 1'b0;
        mainCtrl_p1 <= '0;
        skidVld_p1  <= 1'b0;
        skidCtrl_p1 <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) begin
          mainData_p1 <= '0;
          skidData_p1 <= '0;
        end
      end else if (outFire || !mainVld_p1) begin
        // Main slot is free this edge; the older skid beat goes first.
        // A valid skid implies in_ready=0, so no in_fire competes with it.
        if (skidVld_p1) begin
          mainVld_p1  <= 1'b1;
          mainCtrl_p1 <= skidCtrl_p1;
          mainData_p1 <= skidData_p1;
          skidVld_p1  <= 1'b0;
          skidCtrl_p1 <= '0;
        end else if (inFire) begin
          mainVld_p1  <= 1'b1;
          mainCtrl_p1 <= inBus.ctrl;
          mainData_p1 <= inBus.data;
        end else begin
          mainVld_p1  <= 1'b0;
          mainCtrl_p1 <= '0;
          if (CLEAR_DATA_ON_FLUSH != 0) mainData_p1 <= '0;
        end
      end else if (inFire) begin
        // Main is held by back-pressure: park the new beat in the skid.
        skidVld_p1  <= 1'b1;
        skidCtrl_p1 <= inBus.ctrl;
        skidData_p1 <= inBus.data;
      end

      if (stallNow) stallCnt_p1 <= satInc(stallCnt_p1);
    end
  end

`else

  assign inBus.ready = ~mainVld_p1 | outBus.ready;

  // ---- stage p1: single main entry ----
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mainVld_p1  <= 1'b0;
      mainCtrl_p1 <= '0;
      mainData_p1 <= '0;
      stallCnt_p1 <= '0;
    end else begin
      if (flush) begin
        mainVld_p1  <= 1'b0;
        mainCtrl_p1 <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) mainData_p1 <= '0;
      end else if (inFire) begin
        mainVld_p1  <= 1'b1;
        mainCtrl_p1 <= inBus.ctrl;
        mainData_p1 <= inBus.data;
      end else if (outFire) begin
        // Bubble: ctrl forced to zero so nothing downstream writes state.
        mainVld_p1  <= 1'b0;
        mainCtrl_p1 <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) mainData_p1 <= '0;
      end

      if (stallNow) stallCnt_p1 <= satInc(stallCnt_p1);
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 14;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic CLR_N;
  logic flush;
  logic [15:0] cnt;
  logic [2:0]  cnt2;

  int nTests = 0;
  int nFail  = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) inB  ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) outB ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) inB2 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) outB2 ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .flush(flush),
    .inBus(inB), .outBus(outB), .stall_cnt(cnt));

  // Narrow-counter copy fed with identical stimulus, used for saturation.
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(3)) dut2 (
    .CLK(CLK), .CLR_N(CLR_N), .flush(flush),
    .inBus(inB2), .outBus(outB2), .stall_cnt(cnt2));

  assign inB2.valid  = inB.valid;
  assign inB2.ctrl   = inB.ctrl;
  assign inB2.data   = inB.data;
  assign outB2.ready = outB.ready;

  function automatic logic [DW-1:0] dataOf(input logic [CW-1:0] c);
    return {4'hA, c, ~c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c);
    inB.valid = 1'b1;
    inB.ctrl  = c;
    inB.data  = dataOf(c);
  endtask

  // Scoreboard: beats accepted upstream are queued; every beat taken
  // downstream must match the oldest queued one. Flush/reset empty it.
  logic [CW-1:0] sbCtrl[$];
  logic [DW-1:0] sbData[$];

  always @(negedge CLK) begin
    if (!CLR_N) begin
      sbCtrl.delete();
      sbData.delete();
    end else begin
      check("bubble_ctrl_zero", 32'(outB.valid ? '0 : outB.ctrl), 32'd0);
      if (outB.valid && outB.ready) begin
        check("sb_beat_expected", 32'(sbCtrl.size() != 0), 32'd1);
        if (sbCtrl.size() != 0) begin
          check("sb_ctrl", 32'(outB.ctrl), 32'(sbCtrl[0]));
          check("sb_data", 32'(outB.data), 32'(sbData[0]));
          void'(sbCtrl.pop_front());
          void'(sbData.pop_front());
        end
      end
      if (flush) begin
        sbCtrl.delete();
        sbData.delete();
      end else if (inB.valid && inB.ready) begin
        sbCtrl.push_back(inB.ctrl);
        sbData.push_back(inB.data);
      end
    end
  end

  initial begin
    logic expRdy;
`ifdef PIPE_SKID_EN
    expRdy = 1'b1;
`else
    expRdy = 1'b0;
`endif

    // Reset held with random inputs
    CLR_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inB.valid  = 1'($urandom);
      inB.ctrl   = CW'($urandom);
      inB.data   = DW'($urandom);
      outB.ready = 1'($urandom);
      flush      = 1'($urandom);
      tick();
    end
    check("rst_out_valid", 32'(outB.valid), 32'd0);
    check("rst_out_ctrl",  32'(outB.ctrl),  32'd0);
    check("rst_out_data",  32'(outB.data),  32'd0);
    check("rst_stall_cnt", 32'(cnt),        32'd0);
    check("rst_in_ready",  32'(inB.ready),  32'd1);

    inB.valid = 1'b0; flush = 1'b0; outB.ready = 1'b0;
    CLR_N = 1'b1;
    #1 check("release_in_ready", 32'(inB.ready), 32'd1);
    tick();
    check("idle_in_ready",  32'(inB.ready),  32'd1);
    check("idle_out_valid", 32'(outB.valid), 32'd0);

    // Streaming 1..8 with downstream always ready
    outB.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(CW'(i));
      tick();
      check("stream_valid", 32'(outB.valid), 32'd1);
      check("stream_ctrl",  32'(outB.ctrl),  32'(i));
    end
    inB.valid = 1'b0;
    tick();
    check("stream_drained", 32'(outB.valid), 32'd0);
    check("stream_no_stall", 32'(cnt), 32'd0);

    // Stall with 0x2A5 held, next beat 0x155 waiting upstream
    outB.ready = 1'b0;
    send(CW'(14'h2A5));
    tick();
    check("stall_load_valid", 32'(outB.valid), 32'd1);
    check("stall_load_ctrl",  32'(outB.ctrl),  32'h2A5);
    send(CW'(14'h155));
    #1 check("stall_first_in_ready", 32'(inB.ready), 32'(expRdy));
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("stall_valid",    32'(outB.valid), 32'd1);
      check("stall_ctrl",     32'(outB.ctrl),  32'h2A5);
      check("stall_in_ready", 32'(inB.ready),  32'd0);
      check("stall_cnt",      32'(cnt),        32'(k));
      check("stall_cnt_sat",  32'(cnt2),       32'((k > 7) ? 7 : k));
    end

    // Asynchronous reset between edges while stalled
    #2 CLR_N = 1'b0;
    #1;
    check("arst_out_valid", 32'(outB.valid), 32'd0);
    check("arst_out_ctrl",  32'(outB.ctrl),  32'd0);
    check("arst_out_data",  32'(outB.data),  32'd0);
    check("arst_stall_cnt", 32'(cnt),        32'd0);
    check("arst_cnt_sat",   32'(cnt2),       32'd0);
    check("arst_in_ready",  32'(inB.ready),  32'd1);
    inB.valid = 1'b0; outB.ready = 1'b0;
    #3 CLR_N = 1'b1;
    tick();
    check("post_arst_valid",    32'(outB.valid), 32'd0);
    check("post_arst_in_ready", 32'(inB.ready),  32'd1);
    outB.ready = 1'b1;
    send(CW'(14'h011));
    tick();
    check("post_arst_ctrl", 32'(outB.ctrl), 32'h011);
    inB.valid = 1'b0;
    tick();
    check("post_arst_drain", 32'(outB.valid), 32'd0);

    // Flush colliding with an accepted beat
    outB.ready = 1'b0;
    send(CW'(14'h0AA));
    tick();
    check("flush_pre_ctrl", 32'(outB.ctrl), 32'h0AA);
    send(CW'(14'h3FF));
    outB.ready = 1'b1;
    flush = 1'b1;
    #1 check("flush_in_ready", 32'(inB.ready), 32'd1);
    tick();
    check("flush_valid", 32'(outB.valid), 32'd0);
    check("flush_ctrl",  32'(outB.ctrl),  32'd0);
    check("flush_data_hold", 32'(outB.data), 32'(dataOf(CW'(14'h0AA))));
    flush = 1'b0;
    inB.valid = 1'b0;
    tick();
    check("flush_beat_dropped", 32'(outB.valid), 32'd0);

    // Flush during a stall is not counted as a stall cycle
    outB.ready = 1'b0;
    send(CW'(14'h0BB));
    tick();
    check("flush_stall_load", 32'(outB.valid), 32'd1);
    inB.valid = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_stall_cnt",   32'(cnt),        32'd0);
    check("flush_stall_valid", 32'(outB.valid), 32'd0);
    flush = 1'b0;
    tick();
    check("flush_stall_cnt_after", 32'(cnt), 32'd0);

    // Final drain
    outB.ready = 1'b1;
    tick();
    tick();
    check("sb_drained", 32'(sbCtrl.size()), 32'd0);
    check("end_valid",  32'(outB.valid),    32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register. It is the generic successor of the fixed ID/EX register.
- Carries a control field and a datapath field between two CPU stages using valid/ready flow control, plus a synchronous flush that inserts a bubble.
- Adds back-pressure (stall), valid tracking, an optional skid entry for full throughput, and a saturating stall-cycle counter.
- One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 14: control-field width; for ID/EX this is RegWrite, ALUSrc, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[3:0], JalSrc, USrc, UOControl.
- DATA_W, 175: datapath-field width; for ID/EX this is RD1, RD2, PC, PCPlus4, ImmExt (5x32) plus Rs1, Rs2, Rd (3x5).
- CLEAR_DATA_ON_FLUSH, 0: 1 = flush and bubbles also zero the data field; 0 = data field holds its last value.
- CNT_W, 16: width of stall_cnt.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of stage contents and of the incoming beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream datapath field.
- out_valid  out  1  stage holds a valid beat.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  registered control field.
- out_data  out  DATA_W  registered datapath field.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (CLR_N=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - Skid entry (if present) is empty and cleared.
  - in_ready=1 while reset is held and in the first cycle after release.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - A beat never changes while out_valid=1 and out_ready=0.
  - Latency is 1 cycle from in_fire to out_valid.
- Without skid (PIPE_SKID_EN undefined):
  - in_ready = !out_valid | out_ready (combinational).
  - On in_fire: main register loads in_ctrl/in_data; out_valid<=1.
  - Else if out_fire: out_valid<=0 and out_ctrl<=0. out_data is zeroed only if CLEAR_DATA_ON_FLUSH=1.
  - Else: hold.
- Invariant: out_ctrl==0 whenever out_valid==0. A bubble therefore can never write registers or memory downstream.
- Flush (flush=1 at a clock edge):
  - Next cycle out_valid=0, out_ctrl=0, skid emptied; out_data is zeroed only if CLEAR_DATA_ON_FLUSH=1.
  - A beat presented with in_fire in the same cycle is consumed and discarded; it does not appear at the output.
  - Flush has priority over in_fire, out_fire and stall.
- Back-to-back streaming:
  - With out_ready=1 continuously, one beat is transferred per cycle and no beat is dropped or duplicated.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0 and flush=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Reset mid-operation: asynchronous assertion immediately forces the reset values above; any in-flight beat is lost.

Optional Feature:
- Macro PIPE_SKID_EN.
- Defined: a second skid entry is added.
  - in_ready is registered and equals !skid_valid, which removes the combinational ready path from out_ready to in_ready.
  - If in_fire occurs while main is valid and out_ready=0, the beat goes to the skid entry.
  - On out_fire with skid valid, main loads from skid and skid empties in the same edge.
  - Output order is strictly FIFO.
  - Full-throughput streaming is preserved.
- Undefined: single-entry behaviour as above, with combinational in_ready.

Test Plan:
- Reset/idle: hold CLR_N=0 with random inputs, then release -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
- Streaming: send ctrl 0x0001..0x0008 with out_ready=1 every cycle -> the same 8 beats appear in order, each exactly 1 cycle later, with no gaps.
- Stall: load ctrl=0x2A5, then out_ready=0 for 5 cycles -> out_ctrl stays 0x2A5, out_valid=1, stall_cnt=5. Without skid, in_ready=0 throughout; with skid, the next beat is accepted once and then in_ready=0.
- Flush collision: out_valid=1 and in_fire of ctrl=0x3FF in the same cycle as flush=1 -> next cycle out_valid=0, out_ctrl=0; the 0x3FF beat never appears at the output.
- Saturation: set CNT_W=3 and hold a stall for 10 cycles -> stall_cnt reaches 7 and stays at 7.
- Async reset mid-stall (skid full): drop CLR_N between edges -> outputs go to reset values without waiting for a clock edge, and the skid entry is empty after release.
